// File: rtl/z80_bus_pkg.sv
// Shared constants and types for the NextZ80 bus responder: register map,
// control bits, reset values, request kinds and wait-FSM states.
package z80_bus_pkg;

  localparam logic [7:0] REG_TMR_LO = 8'd0;
  localparam logic [7:0] REG_TMR_HI = 8'd1;
  localparam logic [7:0] REG_CTRL   = 8'd2;
  localparam logic [7:0] REG_STATUS = 8'd3;
  localparam logic [7:0] REG_VECTOR = 8'd4;
  localparam int unsigned REG_COUNT = 5;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  localparam logic [15:0] TMR_RST    = 16'hFFFF;
  localparam logic [7:0]  VECTOR_RST = 8'hFF;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_MEM,
    REQ_IO,
    REQ_ACK
  } req_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } wait_state_e;

endpackage

// File: rtl/z80_timer.sv
// 16-bit reloading down-counter with a sticky pending flag.
module z80_timer
  import z80_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] reload,
  output logic        pend
);

  logic [15:0] count;
  logic        expire;

  assign expire = en && !load && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= TMR_RST;
      pend  <= 1'b0;
    end else begin
      if (load) begin
        count <= reload;
      end else if (en) begin
        if (count == '0) count <= reload;
        else             count <= count - 16'd1;
      end
      // A set in the same cycle as a clear leaves PEND asserted.
      if (expire)     pend <= 1'b1;
      else if (clear) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Target end of the NextZ80 MREQ/IORQ/M1 bus: RAM, timer registers,
// wait-state generation and IM2-style interrupt acknowledge.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [7:0]  IO_BASE  = 8'h10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DO,
  input  logic        WR,
  input  logic        MREQ,
  input  logic        IORQ,
  input  logic        M1,
  output logic [7:0]  DI,
  output logic        WAIT,
  output logic        INT
);

  req_kind_e   req;
  wait_state_e state, state_n;
  logic [3:0]  cnt, cnt_n, n_wait;
  logic        wait_req, done, commit;

  logic [7:0]  ram [2**RAM_AW];
  logic        ram_hit;
  logic [8:0]  io_diff;
  logic        io_hit;
  logic [7:0]  io_off;
  logic [7:0]  io_rd;

  logic [7:0]  tmr_lo, tmr_hi, vector;
  logic        ctrl_en, ctrl_ie, pend;
  logic        mem_wr, io_wr, timer_load, timer_clear;

  always_comb begin
    req = REQ_NONE;
    if (IORQ && M1) req = REQ_ACK;
    else if (MREQ)  req = REQ_MEM;
    else if (IORQ)  req = REQ_IO;
  end

  always_comb begin
    n_wait = '0;
    case (req)
      REQ_MEM: n_wait = 4'(MEM_WAIT);
      REQ_IO:  n_wait = 4'(IO_WAIT);
      default: n_wait = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wait_req = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != REQ_NONE) begin
          if (n_wait != '0) begin
            wait_req = 1'b1;
            state_n  = ST_STALL;
            cnt_n    = n_wait - 4'd1;
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (req == REQ_NONE) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end else begin
          wait_req = 1'b1;
          cnt_n    = cnt - 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Gated by RESET so an access in flight is dropped the moment reset asserts.
  assign WAIT   = RESET && wait_req;
  assign commit = RESET && done;

  assign ram_hit = (ADDR >> RAM_AW) == '0;
  assign io_diff = {1'b0, ADDR[7:0]} - {1'b0, IO_BASE};
  assign io_hit  = io_diff < 9'(REG_COUNT);
  assign io_off  = io_diff[7:0];

  assign mem_wr = commit && WR && (req == REQ_MEM) && ram_hit;
  assign io_wr  = commit && WR && (req == REQ_IO) && io_hit;

  always_ff @(posedge CLK) begin
    if (mem_wr) ram[ADDR[RAM_AW-1:0]] <= DO;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tmr_lo  <= TMR_RST[7:0];
      tmr_hi  <= TMR_RST[15:8];
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      vector  <= VECTOR_RST;
    end else if (io_wr) begin
      case (io_off)
        REG_TMR_LO: tmr_lo <= DO;
        REG_TMR_HI: tmr_hi <= DO;
        REG_CTRL: begin
          ctrl_en <= DO[CTRL_EN];
          ctrl_ie <= DO[CTRL_IE];
        end
        REG_VECTOR: vector <= DO;
        default: ;
      endcase
    end
  end

  assign timer_load  = io_wr && (io_off == REG_CTRL) && DO[CTRL_EN] && !ctrl_en;
  assign timer_clear = (io_wr && (io_off == REG_STATUS) && DO[0]) ||
                       (commit && (req == REQ_ACK));

  z80_timer u_timer (
    .clk    (CLK),
    .rst_n  (RESET),
    .load   (timer_load),
    .clear  (timer_clear),
    .en     (ctrl_en),
    .reload ({tmr_hi, tmr_lo}),
    .pend   (pend)
  );

  assign INT = pend && ctrl_ie;

  always_comb begin
    io_rd = OPEN_BUS;
    case (io_off)
      REG_TMR_LO: io_rd = tmr_lo;
      REG_TMR_HI: io_rd = tmr_hi;
      REG_CTRL:   io_rd = {6'b0, ctrl_ie, ctrl_en};
      REG_STATUS: io_rd = {7'b0, pend};
      REG_VECTOR: io_rd = vector;
      default:    io_rd = OPEN_BUS;
    endcase
  end

  always_comb begin
    DI = OPEN_BUS;
    case (req)
      REQ_MEM: DI = ram_hit ? ram[ADDR[RAM_AW-1:0]] : OPEN_BUS;
      REQ_IO:  DI = io_hit ? io_rd : OPEN_BUS;
      REQ_ACK: DI = vector;
      default: DI = OPEN_BUS;
    endcase
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder (MEM_WAIT=0, IO_WAIT=3, IO_BASE=0x10).
module tb_z80_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] ADDR = '0;
  logic [7:0]  DO = '0;
  logic        WR = 1'b0, MREQ = 1'b0, IORQ = 1'b0, M1 = 1'b0;
  logic [7:0]  DI;
  logic        WAIT, INT;

  int total = 0;
  int bad   = 0;

  z80_bus_responder #(
    .RAM_AW   (10),
    .MEM_WAIT (0),
    .IO_WAIT  (3),
    .IO_BASE  (8'h10)
  ) dut (
    .CLK (CLK), .RESET (RESET), .ADDR (ADDR), .DO (DO), .WR (WR),
    .MREQ (MREQ), .IORQ (IORQ), .M1 (M1), .DI (DI), .WAIT (WAIT), .INT (INT)
  );

  always #5 CLK = ~CLK;

  task automatic bus_idle();
    MREQ = 1'b0; IORQ = 1'b0; M1 = 1'b0; WR = 1'b0;
  endtask

  // kind: 0 memory, 1 I/O, 2 interrupt acknowledge.
  task automatic bus_access(input int kind, input logic wr_en, input logic [15:0] addr,
                            input logic [7:0] data, output logic [7:0] rd, output int waits);
    bit fin;
    @(negedge CLK);
    MREQ = (kind == 0); IORQ = (kind != 0); M1 = (kind == 2);
    WR = wr_en; ADDR = addr; DO = data;
    waits = 0; rd = 8'h00; fin = 0;
    while (!fin) begin
      #1;
      if (WAIT === 1'b0) begin
        rd = DI; fin = 1;
      end else begin
        waits++;
        if (waits > 20) begin
          total++; bad++;
          $display("FAIL bus_timeout addr=%h: WAIT still high after %0d cycles", addr, waits);
          fin = 1;
        end else begin
          @(negedge CLK);
        end
      end
    end
    @(posedge CLK);
    #1 bus_idle();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1;
    total++; if (WAIT !== 1'b0) begin bad++; $display("FAIL reset_wait: got %b want 0", WAIT); end
    total++; if (INT !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", INT); end
    total++; if (DI !== 8'hFF) begin bad++; $display("FAIL reset_di: got %h want ff", DI); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
  endtask

  task automatic test_io_read();
    logic [7:0] rd; int w;
    bus_access(1, 0, 16'h0014, 8'h00, rd, w);
    total++; if (w !== 3) begin bad++; $display("FAIL io_vec_waits: got %0d want 3", w); end
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_vec_rd: got %h want ff", rd); end
    bus_access(1, 0, 16'h0010, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_tmrlo_rst: got %h want ff", rd); end
    bus_access(1, 0, 16'h0011, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_tmrhi_rst: got %h want ff", rd); end
    bus_access(1, 0, 16'h0012, 8'h00, rd, w);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL io_ctrl_rst: got %h want 00", rd); end
    bus_access(1, 0, 16'h0013, 8'h00, rd, w);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL io_status_rst: got %h want 00", rd); end
  endtask

  task automatic test_mem();
    logic [7:0] rd; int w;
    bus_access(0, 1, 16'h0123, 8'hA5, rd, w);
    total++; if (w !== 0) begin bad++; $display("FAIL mem_wr_waits: got %0d want 0", w); end
    bus_access(0, 0, 16'h0123, 8'h00, rd, w);
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL mem_rd: got %h want a5", rd); end
    total++; if (w !== 0) begin bad++; $display("FAIL mem_rd_waits: got %0d want 0", w); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int w;
    bus_access(0, 1, 16'h0000, 8'h3C, rd, w);
    bus_access(0, 1, 16'h03FF, 8'h5A, rd, w);
    bus_access(0, 0, 16'h0000, 8'h00, rd, w);
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL b2b_rd0: got %h want 3c", rd); end
    bus_access(0, 0, 16'h03FF, 8'h00, rd, w);
    total++; if (rd !== 8'h5A) begin bad++; $display("FAIL b2b_rd3ff: got %h want 5a", rd); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; int w;
    bus_access(0, 1, 16'h8000, 8'h55, rd, w);
    bus_access(0, 0, 16'h8000, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL oor_rd8000: got %h want ff", rd); end
    bus_access(0, 1, 16'h0400, 8'h77, rd, w);
    bus_access(0, 0, 16'h0400, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL oor_rd0400: got %h want ff", rd); end
    bus_access(0, 0, 16'h0000, 8'h00, rd, w);
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL oor_ram0: got %h want 3c", rd); end
    bus_access(0, 0, 16'h0123, 8'h00, rd, w);
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL oor_ram123: got %h want a5", rd); end
  endtask

  task automatic test_io_unmapped();
    logic [7:0] rd; int w;
    bus_access(1, 0, 16'h0015, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_unmap_hi: got %h want ff", rd); end
    bus_access(1, 0, 16'h000F, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_unmap_lo: got %h want ff", rd); end
    bus_access(1, 1, 16'h0015, 8'h00, rd, w);
    bus_access(1, 0, 16'h0010, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL io_unmap_wr: got %h want ff", rd); end
  endtask

  task automatic test_abandon();
    logic [7:0] rd; int w;
    @(negedge CLK);
    IORQ = 1'b1; WR = 1'b1; ADDR = 16'h0010; DO = 8'h77;
    #1;
    total++; if (WAIT !== 1'b1) begin bad++; $display("FAIL abandon_wait1: got %b want 1", WAIT); end
    @(negedge CLK);
    #1;
    total++; if (WAIT !== 1'b1) begin bad++; $display("FAIL abandon_wait2: got %b want 1", WAIT); end
    bus_idle();
    #1;
    total++; if (WAIT !== 1'b0) begin bad++; $display("FAIL abandon_wait_drop: got %b want 0", WAIT); end
    repeat (3) @(posedge CLK);
    bus_access(1, 0, 16'h0010, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL abandon_nowrite: got %h want ff", rd); end
  endtask

  task automatic test_timer_irq();
    logic [7:0] rd; int w;
    logic exp_int;
    bus_access(1, 1, 16'h0010, 8'h04, rd, w);
    bus_access(1, 1, 16'h0011, 8'h00, rd, w);
    bus_access(1, 1, 16'h0014, 8'h40, rd, w);
    bus_access(1, 1, 16'h0012, 8'h03, rd, w);
    for (int i = 1; i <= 5; i++) begin
      @(posedge CLK);
      #1;
      exp_int = (i == 5);
      total++;
      if (INT !== exp_int) begin
        bad++; $display("FAIL timer_int_cycle%0d: got %b want %b", i, INT, exp_int);
      end
    end
    bus_access(2, 0, 16'h0000, 8'h00, rd, w);
    total++; if (rd !== 8'h40) begin bad++; $display("FAIL ack_vector: got %h want 40", rd); end
    total++; if (w !== 0) begin bad++; $display("FAIL ack_waits: got %0d want 0", w); end
    total++; if (INT !== 1'b0) begin bad++; $display("FAIL ack_int_clear: got %b want 0", INT); end
    bus_access(1, 1, 16'h0012, 8'h00, rd, w);
    bus_access(1, 1, 16'h0013, 8'h01, rd, w);
    bus_access(1, 0, 16'h0013, 8'h00, rd, w);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL timer_status_clr: got %h want 00", rd); end
  endtask

  task automatic test_set_wins();
    logic [7:0] rd; int w;
    bus_access(1, 1, 16'h0010, 8'h00, rd, w);
    bus_access(1, 1, 16'h0012, 8'h03, rd, w);
    bus_access(1, 1, 16'h0013, 8'h01, rd, w);
    total++; if (INT !== 1'b1) begin bad++; $display("FAIL setwins_int: got %b want 1", INT); end
    bus_access(1, 0, 16'h0013, 8'h00, rd, w);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL setwins_status: got %h want 01", rd); end
    bus_access(1, 0, 16'h0012, 8'h00, rd, w);
    total++; if (rd !== 8'h03) begin bad++; $display("FAIL setwins_ctrl: got %h want 03", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; int w;
    @(negedge CLK);
    IORQ = 1'b1; WR = 1'b1; ADDR = 16'h0010; DO = 8'h12;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    total++; if (WAIT !== 1'b1) begin bad++; $display("FAIL rstmid_wait_pre: got %b want 1", WAIT); end
    RESET = 1'b0;
    #1;
    total++; if (WAIT !== 1'b0) begin bad++; $display("FAIL rstmid_wait: got %b want 0", WAIT); end
    total++; if (INT !== 1'b0) begin bad++; $display("FAIL rstmid_int: got %b want 0", INT); end
    bus_idle();
    #1;
    total++; if (DI !== 8'hFF) begin bad++; $display("FAIL rstmid_di_idle: got %h want ff", DI); end
    @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    bus_access(1, 0, 16'h0010, 8'h00, rd, w);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL rstmid_tmrlo: got %h want ff", rd); end
    bus_access(1, 0, 16'h0012, 8'h00, rd, w);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL rstmid_ctrl: got %h want 00", rd); end
    bus_access(0, 0, 16'h0123, 8'h00, rd, w);
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL rstmid_ram_kept: got %h want a5", rd); end
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_mem();
    test_back_to_back();
    test_out_of_range();
    test_io_unmapped();
    test_abandon();
    test_timer_irq();
    test_set_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
